// File: rtl/agu_pkg.sv
// Shared encodings for the effective-address sequencer: addressing modes,
// FSM states and the default stack page.
package agu_pkg;

  typedef enum logic [2:0] {
    MODE_ZP   = 3'd0,
    MODE_ZPX  = 3'd1,
    MODE_ABS  = 3'd2,
    MODE_ABSX = 3'd3,
    MODE_INDX = 3'd4,
    MODE_INDY = 3'd5,
    MODE_PUSH = 3'd6,
    MODE_POP  = 3'd7
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLO,
    ST_PHI,
    ST_CALC,
    ST_FIX
  } state_e;

  localparam int STACK_PAGE_DEFAULT = 1;

endpackage

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module flopenr #(
  parameter int            W  = 8,
  parameter logic [W-1:0]  RV = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RV;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ea_sequencer.sv
// Effective-address sequencer: owns index registers and S, resolves indexed,
// indirect and stack modes, issues pointer/dummy reads, pulses EA_VALID.
module ea_sequencer
  import agu_pkg::*;
#(
  parameter int            DW         = 8,
  parameter int            NIDX       = 2,
  parameter logic [DW-1:0] S_INIT     = '1,
  parameter logic [DW-1:0] STACK_PAGE = DW'(STACK_PAGE_DEFAULT),
  localparam int           AW         = 2 * DW,
  localparam int           ISW        = (NIDX > 1) ? $clog2(NIDX) : 1,
  localparam int           RSW        = $clog2(NIDX + 1)
) (
  input  logic               CLK,
  input  logic               RES_N,
  input  logic               START,
  input  logic [2:0]         MODE,
  input  logic [ISW-1:0]     IDX_SEL,
  input  logic               FORCE_FIX,
  input  logic [AW-1:0]      OPER,
  output logic               READY,
  output logic               EA_VALID,
  output logic [AW-1:0]      EA,
  output logic               PAGE_CROSS,
  output logic               MEM_RD,
  output logic [AW-1:0]      MEM_AB,
  output logic               DUMMY_RD,
  input  logic               MEM_RDY,
  input  logic [DW-1:0]      DB_IN,
  input  logic               REG_WE,
  input  logic [RSW-1:0]     REG_SEL,
  input  logic [DW-1:0]      REG_WD,
  output logic [NIDX*DW-1:0] IDX_OUT,
  output logic [DW-1:0]      S_OUT
);

  logic [DW-1:0] idx_r [NIDX];
  logic [DW-1:0] s_r;

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic          force_q, force_d;
  logic [AW-1:0] base_q, base_d;
  logic [DW-1:0] idx_q, idx_d;
  logic [DW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [AW-1:0] ea_q, ea_d;
  logic          pc_q, pc_d;
  logic          ea_valid_q, load_ea;

  logic          s_step;
  logic [DW-1:0] s_step_val;
  logic          s_wr;
  logic [DW-1:0] idx_now;
  logic [DW:0]   zp_add, phi_add, fix_add;

  for (genvar i = 0; i < NIDX; i++) begin : g_idx
    flopenr #(.W(DW), .RV('0)) u_idx (
      .clk   (CLK),
      .rst_n (RES_N),
      .en    (REG_WE && (REG_SEL == RSW'(i))),
      .d     (REG_WD),
      .q     (idx_r[i])
    );
    assign IDX_OUT[i*DW +: DW] = idx_r[i];
  end

  // A register write to S overrides a same-edge PUSH/POP step.
  assign s_wr = REG_WE && (REG_SEL == RSW'(NIDX));

  flopenr #(.W(DW), .RV(S_INIT)) u_s (
    .clk   (CLK),
    .rst_n (RES_N),
    .en    (s_wr || s_step),
    .d     (s_wr ? REG_WD : s_step_val),
    .q     (s_r)
  );

  always_comb begin
    idx_now = '0;
    for (int i = 0; i < NIDX; i++) begin
      if (IDX_SEL == ISW'(i)) idx_now = idx_r[i];
    end
  end

  assign zp_add  = {1'b0, OPER[DW-1:0]} + {1'b0, idx_now};
  assign phi_add = {1'b0, lo_q} + {1'b0, idx_q};
  assign fix_add = {1'b0, base_q[DW-1:0]} + {1'b0, idx_q};

  // The index add of (zp),Y is resolved on the PHI completion edge so the
  // no-fix-up path stays at three cycles; ST_CALC is therefore never entered.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    force_d    = force_q;
    base_d     = base_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    lo_d       = lo_q;
    ea_d       = ea_q;
    pc_d       = 1'b0;
    load_ea    = 1'b0;
    s_step     = 1'b0;
    s_step_val = s_r;
    MEM_RD     = 1'b0;
    DUMMY_RD   = 1'b0;
    MEM_AB     = '0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mode_d  = mode_e'(MODE);
          force_d = FORCE_FIX;
          base_d  = OPER;
          idx_d   = idx_now;
          case (mode_e'(MODE))
            MODE_ZP: begin
              load_ea = 1'b1;
              ea_d    = {{DW{1'b0}}, OPER[DW-1:0]};
            end
            MODE_ZPX: begin
              load_ea = 1'b1;
              ea_d    = {{DW{1'b0}}, zp_add[DW-1:0]};
            end
            MODE_ABS: begin
              load_ea = 1'b1;
              ea_d    = OPER;
            end
            MODE_ABSX: begin
              if (zp_add[DW] || FORCE_FIX) begin
                state_d = ST_FIX;
              end else begin
                load_ea = 1'b1;
                ea_d    = {OPER[AW-1:DW], zp_add[DW-1:0]};
              end
            end
            MODE_INDX: begin
              ptr_d   = zp_add[DW-1:0];
              state_d = ST_PLO;
            end
            MODE_INDY: begin
              ptr_d   = OPER[DW-1:0];
              state_d = ST_PLO;
            end
            MODE_PUSH: begin
              load_ea    = 1'b1;
              ea_d       = {STACK_PAGE, s_r};
              s_step     = 1'b1;
              s_step_val = s_r - 1'b1;
            end
            MODE_POP: begin
              load_ea    = 1'b1;
              s_step     = 1'b1;
              s_step_val = s_r + 1'b1;
              ea_d       = {STACK_PAGE, s_step_val};
            end
          endcase
        end
      end

      ST_PLO: begin
        MEM_RD = 1'b1;
        MEM_AB = {{DW{1'b0}}, ptr_q};
        if (MEM_RDY) begin
          lo_d    = DB_IN;
          state_d = ST_PHI;
        end
      end

      ST_PHI: begin
        MEM_RD = 1'b1;
        MEM_AB = {{DW{1'b0}}, ptr_q + 1'b1};
        if (MEM_RDY) begin
          if (mode_q == MODE_INDX) begin
            load_ea = 1'b1;
            ea_d    = {DB_IN, lo_q};
            state_d = ST_IDLE;
          end else begin
            base_d = {DB_IN, lo_q};
            if (phi_add[DW] || force_q) begin
              state_d = ST_FIX;
            end else begin
              load_ea = 1'b1;
              ea_d    = {DB_IN, phi_add[DW-1:0]};
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_FIX: begin
        // Dummy read at the uncorrected address, as the 6502 does.
        MEM_RD   = 1'b1;
        DUMMY_RD = 1'b1;
        MEM_AB   = {base_q[AW-1:DW], fix_add[DW-1:0]};
        if (MEM_RDY) begin
          load_ea = 1'b1;
          ea_d    = base_q + {{DW{1'b0}}, idx_q};
          pc_d    = fix_add[DW];
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ZP;
      force_q    <= 1'b0;
      base_q     <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      lo_q       <= '0;
      ea_q       <= '0;
      pc_q       <= 1'b0;
      ea_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      force_q    <= force_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      lo_q       <= lo_d;
      ea_valid_q <= load_ea;
      if (load_ea) begin
        ea_q <= ea_d;
        pc_q <= pc_d;
      end
    end
  end

  assign READY      = (state_q == ST_IDLE);
  assign EA_VALID   = ea_valid_q;
  assign EA         = ea_q;
  assign PAGE_CROSS = pc_q;
  assign S_OUT      = s_r;

endmodule

// File: tb/tb_ea_sequencer.sv
// Self-checking bench for ea_sequencer: vector table driven through a
// scoreboard queue, plus hand-written stack and reset-abort sequences.
module tb_ea_sequencer;

  logic        CLK = 1'b0;
  logic        RES_N = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  MODE = '0;
  logic [0:0]  IDX_SEL = '0;
  logic        FORCE_FIX = 1'b0;
  logic [15:0] OPER = '0;
  logic        READY, EA_VALID, PAGE_CROSS, MEM_RD, DUMMY_RD;
  logic [15:0] EA, MEM_AB;
  logic        MEM_RDY = 1'b1;
  logic [7:0]  DB_IN;
  logic        REG_WE = 1'b0;
  logic [1:0]  REG_SEL = '0;
  logic [7:0]  REG_WD = '0;
  logic [15:0] IDX_OUT;
  logic [7:0]  S_OUT;

  logic [7:0] zp_mem [256];
  assign DB_IN = zp_mem[MEM_AB[7:0]];

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  ea_sequencer dut (
    .CLK(CLK), .RES_N(RES_N), .START(START), .MODE(MODE), .IDX_SEL(IDX_SEL),
    .FORCE_FIX(FORCE_FIX), .OPER(OPER), .READY(READY), .EA_VALID(EA_VALID),
    .EA(EA), .PAGE_CROSS(PAGE_CROSS), .MEM_RD(MEM_RD), .MEM_AB(MEM_AB),
    .DUMMY_RD(DUMMY_RD), .MEM_RDY(MEM_RDY), .DB_IN(DB_IN), .REG_WE(REG_WE),
    .REG_SEL(REG_SEL), .REG_WD(REG_WD), .IDX_OUT(IDX_OUT), .S_OUT(S_OUT)
  );

  typedef struct {
    logic [2:0]  mode;
    logic        sel;
    logic        ff;
    logic [15:0] oper;
    logic [7:0]  x;
    logic [7:0]  y;
    int          stall;
    logic [15:0] ea;
    logic        pc;
    int          lat;
    int          nrd;
    logic [15:0] rd [3];
    int          ndm;
  } vec_t;

  vec_t vecs [13];
  vec_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] mode, input logic sel, input logic ff,
                              input logic [15:0] oper, input logic [7:0] x, input logic [7:0] y,
                              input int stall, input logic [15:0] ea, input logic pc,
                              input int lat, input int nrd, input logic [15:0] r0,
                              input logic [15:0] r1, input logic [15:0] r2, input int ndm);
    vec_t v;
    v.mode = mode; v.sel = sel; v.ff = ff; v.oper = oper; v.x = x; v.y = y;
    v.stall = stall; v.ea = ea; v.pc = pc; v.lat = lat; v.nrd = nrd;
    v.rd[0] = r0; v.rd[1] = r1; v.rd[2] = r2; v.ndm = ndm;
    return v;
  endfunction

  // Entered and left at a falling edge.
  task automatic wr_reg(input logic [1:0] sel, input logic [7:0] val);
    REG_WE = 1'b1; REG_SEL = sel; REG_WD = val;
    @(posedge CLK); #1;
    REG_WE = 1'b0;
    @(negedge CLK);
  endtask

  task automatic issue(input vec_t v);
    vec_t e;
    int   n, rd_n, dm_n, stall;
    bit   done;
    check("ready_before_start", READY, 1);
    START = 1'b1; MODE = v.mode; IDX_SEL = v.sel; FORCE_FIX = v.ff; OPER = v.oper;
    exp_q.push_back(v);
    @(posedge CLK); #1;
    START = 1'b0; REG_WE = 1'b0;
    n = 0; rd_n = 0; dm_n = 0; stall = v.stall; done = 0;
    while (!done && n < 40) begin
      @(negedge CLK);
      n++;
      if (EA_VALID) begin
        done = 1;
      end else if (MEM_RD) begin
        if (stall > 0) begin
          MEM_RDY = 1'b0;
          stall--;
          check("stall_ab_hold", MEM_AB, v.rd[0]);
        end else begin
          MEM_RDY = 1'b1;
          if (rd_n < 3) check($sformatf("read%0d_addr", rd_n), MEM_AB, v.rd[rd_n]);
          if (DUMMY_RD) dm_n++;
          rd_n++;
        end
      end else begin
        MEM_RDY = 1'b1;
      end
    end
    MEM_RDY = 1'b1;
    check("ea_valid_timeout", done, 1);
    e = exp_q.pop_front();
    check($sformatf("ea_mode%0d", e.mode), EA, e.ea);
    check($sformatf("page_cross_mode%0d", e.mode), PAGE_CROSS, e.pc);
    check($sformatf("latency_mode%0d", e.mode), n, e.lat);
    check($sformatf("read_count_mode%0d", e.mode), rd_n, e.nrd);
    check($sformatf("dummy_count_mode%0d", e.mode), dm_n, e.ndm);
    check("ready_in_valid_cycle", READY, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) zp_mem[i] = 8'h00;
    zp_mem[8'h01] = 8'h34; zp_mem[8'h02] = 8'h12;
    zp_mem[8'hFF] = 8'h78; zp_mem[8'h00] = 8'h56;
    zp_mem[8'h40] = 8'h01; zp_mem[8'h41] = 8'h12;

    //            mode sel ff oper      x      y     stl ea       pc lat nrd rd0       rd1       rd2       ndm
    vecs[0]  = mk(3'd0, 0, 0, 16'hAB55, 8'h00, 8'h00, 0, 16'h0055, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[1]  = mk(3'd2, 0, 0, 16'hAB55, 8'h00, 8'h00, 0, 16'hAB55, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[2]  = mk(3'd1, 0, 0, 16'h00F0, 8'h20, 8'h00, 0, 16'h0010, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[3]  = mk(3'd3, 0, 0, 16'h12F8, 8'h10, 8'h00, 0, 16'h1308, 1, 2, 1, 16'h1208, 16'h0000, 16'h0000, 1);
    vecs[4]  = mk(3'd3, 0, 0, 16'h1200, 8'h10, 8'h00, 0, 16'h1210, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[5]  = mk(3'd3, 0, 1, 16'h1200, 8'h10, 8'h00, 0, 16'h1210, 0, 2, 1, 16'h1210, 16'h0000, 16'h0000, 1);
    vecs[6]  = mk(3'd3, 1, 0, 16'h2001, 8'h00, 8'hFF, 0, 16'h2100, 1, 2, 1, 16'h2000, 16'h0000, 16'h0000, 1);
    vecs[7]  = mk(3'd4, 0, 0, 16'h00FD, 8'h04, 8'h00, 0, 16'h1234, 0, 3, 2, 16'h0001, 16'h0002, 16'h0000, 0);
    vecs[8]  = mk(3'd4, 0, 0, 16'h00FF, 8'h00, 8'h00, 0, 16'h5678, 0, 3, 2, 16'h00FF, 16'h0000, 16'h0000, 0);
    vecs[9]  = mk(3'd5, 1, 0, 16'h0040, 8'h00, 8'hFF, 2, 16'h1300, 1, 6, 3, 16'h0040, 16'h0041, 16'h1200, 1);
    vecs[10] = mk(3'd5, 1, 0, 16'h0040, 8'h00, 8'h05, 0, 16'h1206, 0, 3, 2, 16'h0040, 16'h0041, 16'h0000, 0);
    vecs[11] = mk(3'd5, 1, 1, 16'h0040, 8'h00, 8'h05, 0, 16'h1206, 0, 4, 3, 16'h0040, 16'h0041, 16'h1206, 1);
    vecs[12] = mk(3'd1, 1, 0, 16'h0080, 8'h20, 8'h7F, 0, 16'h00FF, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0);

    @(negedge CLK); @(negedge CLK);
    RES_N = 1'b1;
    @(negedge CLK);
    check("rst_ready", READY, 1);
    check("rst_ea_valid", EA_VALID, 0);
    check("rst_ea", EA, 0);
    check("rst_page_cross", PAGE_CROSS, 0);
    check("rst_mem_rd", MEM_RD, 0);
    check("rst_dummy_rd", DUMMY_RD, 0);
    check("rst_mem_ab", MEM_AB, 0);
    check("rst_idx", IDX_OUT, 0);
    check("rst_s", S_OUT, 8'hFF);

    for (int i = 0; i < 13; i++) begin
      wr_reg(2'd0, vecs[i].x);
      wr_reg(2'd1, vecs[i].y);
      check($sformatf("idx_out_vec%0d", i), IDX_OUT, {vecs[i].y, vecs[i].x});
      issue(vecs[i]);
    end

    // Stack: PUSH then POP back-to-back, then PUSH racing a write to S.
    wr_reg(2'd2, 8'h00);
    issue(mk(3'd6, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 16'h0100, 0, 1, 0, 16'h0, 16'h0, 16'h0, 0));
    check("s_after_push", S_OUT, 8'hFF);
    issue(mk(3'd7, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 16'h0100, 0, 1, 0, 16'h0, 16'h0, 16'h0, 0));
    check("s_after_pop", S_OUT, 8'h00);
    REG_WE = 1'b1; REG_SEL = 2'd2; REG_WD = 8'h80;
    issue(mk(3'd6, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 16'h0100, 0, 1, 0, 16'h0, 16'h0, 16'h0, 0));
    check("s_reg_we_wins", S_OUT, 8'h80);

    // Reset while the (zp,X) pointer high byte is being read.
    wr_reg(2'd0, 8'h33);
    wr_reg(2'd2, 8'h44);
    START = 1'b1; MODE = 3'd4; IDX_SEL = 1'b0; FORCE_FIX = 1'b0; OPER = 16'h00FD;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("phi_mem_rd", MEM_RD, 1);
    check("phi_mem_ab", MEM_AB, 16'h0031);
    RES_N = 1'b0;
    #1;
    check("abort_ready", READY, 1);
    check("abort_mem_rd", MEM_RD, 0);
    check("abort_ea_valid", EA_VALID, 0);
    check("abort_s", S_OUT, 8'hFF);
    check("abort_idx", IDX_OUT, 0);
    check("abort_ea", EA, 0);
    @(negedge CLK);
    RES_N = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge CLK);
      if (EA_VALID) seen = 1;
    end
    check("abort_no_ea_valid", seen, 0);

    issue(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ea_sequencer.md
# ea_sequencer

Parametrised effective-address sequencer for the mc6502-family core. It owns the index registers and stack pointer and resolves all indexed, indirect and stack addressing modes into a full address. It issues its own pointer reads with a ready-stalled memory handshake and inserts the page-cross fix-up cycle. The control unit hands it already-fetched operand bytes and receives a one-cycle `EA_VALID` pulse.

## Interface
- `DW`, 8, data width; address width is `AW = 2*DW`, high half = page.
- `NIDX`, 2, number of index registers (X = 0, Y = 1 by default).
- `S_INIT`, all ones, stack pointer reset value.
- `STACK_PAGE`, 1, page (high half) used for stack addresses.
- `CLK`  in  1  clock; all state updates on rising edge.
- `RES_N`  in  1  reset; one clock, reset asynchronous and active-low.
- `START`  in  1  request; accepted on an edge where `START & READY`.
- `MODE`  in  3  0 ZP, 1 ZP+idx, 2 ABS, 3 ABS+idx, 4 (zp+X), 5 (zp)+idx, 6 PUSH, 7 POP.
- `IDX_SEL`  in  clog2(NIDX)  index register used by modes 1, 3, 4, 5.
- `FORCE_FIX`  in  1  always take the fix-up cycle in modes 3 and 5 (stores, RMW).
- `OPER`  in  AW  operand; low half = zp address or abs low, high half = abs high.
- `READY`  out  1  high in IDLE.
- `EA_VALID`  out  1  one-cycle pulse; `EA` is correct.
- `EA`  out  AW  effective address; held until the next accepted request.
- `PAGE_CROSS`  out  1  index add carried into the page; valid with `EA_VALID`, held.
- `MEM_RD`  out  1  pointer or dummy read request.
- `MEM_AB`  out  AW  read address.
- `DUMMY_RD`  out  1  qualifies `MEM_RD` as the 6502 fix-up dummy read.
- `MEM_RDY`  in  1  read completes on an edge where `MEM_RD & MEM_RDY`.
- `DB_IN`  in  DW  read data, sampled on completion.
- `REG_WE`  in  1  register write strobe.
- `REG_SEL`  in  clog2(NIDX+1)  `0..NIDX-1` index registers; `NIDX` = S.
- `REG_WD`  in  DW  write data.
- `IDX_OUT`  out  NIDX*DW  index registers, concatenated.
- `S_OUT`  out  DW  stack pointer.

## Operation
- **States:** IDLE, PLO, PHI, CALC, FIX.
- **Operand and index latch:** on acceptance, `OPER` and the selected index are latched; later register writes do not affect the request in flight.
- **Modes 0/2:** `EA = {0, OPER_L}` or `OPER`. Path: IDLE→IDLE.
- **Mode 1:** `EA = {0, (OPER_L + idx) mod 2^DW}`; the result stays in page 0. `PAGE_CROSS = 0`.
- **Mode 3, no carry and not `FORCE_FIX`:** `EA = OPER + idx`.
- **Mode 3, carry or `FORCE_FIX`:** go to FIX. FIX drives `MEM_RD = DUMMY_RD = 1` with `MEM_AB = {OPER_H, OPER_L + idx}` (uncorrected), then emits the corrected EA.
- **Mode 4:** `ptr = (OPER_L + idx) mod 2^DW`. PLO reads `{0, ptr}`; PHI reads `{0, ptr+1 mod 2^DW}` (wraps in page 0). `EA = {hi, lo}`.
- **Mode 5:** PLO reads `{0, OPER_L}`; PHI reads `{0, OPER_L+1}` (wrapped). CALC adds idx to `{hi, lo}` with the same fix-up rule as mode 3.
- **Mode 6:** `EA = {STACK_PAGE, S}`, then `S <= S - 1` mod 2^DW.
- **Mode 7:** `S <= S + 1`, `EA = {STACK_PAGE, S + 1}`.
- **Register writes:** `REG_WE` writes at any time. When it targets S in the same edge as a PUSH/POP update, `REG_WE` wins.
- **Reset values:** `READY = 1`; `EA`, `EA_VALID`, `PAGE_CROSS`, `MEM_RD`, `DUMMY_RD`, `MEM_AB` = 0; index registers = 0; `S = S_INIT`.
- **Reset mid-operation:** aborts immediately to IDLE; no `EA_VALID`.

## Timing
- Latency is counted in cycles from the acceptance edge to `EA_VALID`, with `MEM_RDY = 1`.
- Modes 0, 1, 2, 6, 7, and mode 3 without fix-up: 1 cycle.
- Mode 3 with fix-up: 2 cycles.
- Mode 4: 3 cycles.
- Mode 5: 3 cycles, or 4 with fix-up.
- Each `MEM_RDY = 0` cycle adds one cycle. `MEM_AB`, `MEM_RD` and `DUMMY_RD` must remain stable until completion.
- `READY` is high in the `EA_VALID` cycle, so back-to-back requests are allowed.
- `S` updates on the same edge that raises `EA_VALID`.

## Structure
- **Package `agu_pkg`:** mode encodings, state enum, and the `STACK_PAGE` default.
- **Sub-modules:** index registers and S reuse the existing `flopenr` cell, one instance per register. There is no other sub-module; the adder and FSM are inline.

## Test plan
- **Mode 3, page cross:** X=0x10, `OPER`=0x12F8 → dummy read at 0x1208, then `EA`=0x1308, `PAGE_CROSS`=1, latency 2.
- **Mode 3, no cross:** X=0x10, `OPER`=0x1200 → `EA`=0x1210, `PAGE_CROSS`=0, latency 1.
- **Mode 1, zero-page wrap:** X=0x20, `OPER_L`=0xF0 → `EA`=0x0010.
- **Mode 4, basic:** X=0x04, `OPER_L`=0xFD, mem[0x0001]=0x34, mem[0x0002]=0x12 → reads at 0x0001 then 0x0002, `EA`=0x1234, latency 3.
- **Mode 4, pointer wrap:** `OPER_L`=0xFF, X=0 → reads at 0x00FF then 0x0000.
- **Mode 5, stalled:** Y=0xFF, pointer data 0x1201, `MEM_RDY` low 2 cycles on the first read → `MEM_AB` held, `EA`=0x1300, `PAGE_CROSS`=1, latency 6.
- **Stack:** S=0x00; PUSH → `EA`=0x0100, S=0xFF. POP → S=0x00, `EA`=0x0100. PUSH with simultaneous `REG_WE` to S of 0x80 → S=0x80.
- **Reset during PHI:** `RES_N` low → `READY`=1, `MEM_RD`=0, no `EA_VALID`; S and index registers return to reset values.
